// File: rtl/dff_to_jkff_counter.sv
// Modulo-N up/down counter built from JK bits emulated on D storage.
// Define DFF_JK_TRACE_EN to expose the per-bit J/K excitation as j_obs/k_obs.
module dff_to_jkff_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc
`ifdef DFF_JK_TRACE_EN
    ,
    output logic [WIDTH-1:0] j_obs,
    output logic [WIDTH-1:0] k_obs
`endif
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    if (WIDTH < 2 || MODULUS < 2 || MODULUS > 2 ** WIDTH) begin : g_bad_param
        $error("dff_to_jkff_counter: illegal WIDTH/MODULUS");
    end

    typedef enum logic [2:0] {
        M_HOLD,
        M_RST,
        M_LOAD,
        M_UP,
        M_DN
    } mode_t;

    mode_t            mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] tup;
    logic [WIDTH-1:0] tdn;
    logic             at_top;
    logic             at_zero;

    assign at_top  = (q >= MAXV);
    assign at_zero = (q == '0);

    // Strict priority collapsed to one mode so the excitation case is exclusive.
    always_comb begin
        mode = M_HOLD;
        if (rst)
            mode = M_RST;
        else if (load)
            mode = M_LOAD;
        else if (en && up)
            mode = M_UP;
        else if (en)
            mode = M_DN;
    end

    // Toggle masks: up toggles above a run of ones, down above a run of zeros.
    always_comb begin
        tup    = '0;
        tdn    = '0;
        tup[0] = 1'b1;
        tdn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            tup[i] = tup[i-1] & q[i-1];
            tdn[i] = tdn[i-1] & ~q[i-1];
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        unique case (mode)
            M_LOAD: begin
                j = din;
                k = ~din;
            end
            M_UP: begin
                if (at_top) begin
                    j = '0;
                    k = q;
                end else begin
                    j = tup;
                    k = tup;
                end
            end
            M_DN: begin
                if (at_zero) begin
                    j = MAXV;
                    k = ~MAXV;
                end else begin
                    j = tdn;
                    k = tdn;
                end
            end
            default: begin
                j = '0;
                k = '0;
            end
        endcase
    end

    assign d = (j & ~q) | (~k & q);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else
            q <= d;
    end

    assign qb = ~q;
    assign tc = en & (up ? at_top : at_zero);

`ifdef DFF_JK_TRACE_EN
    assign j_obs = j;
    assign k_obs = k;
`endif

endmodule

// File: tb/tb_dff_to_jkff_counter.sv
// Directed bench for dff_to_jkff_counter (WIDTH=4, MODULUS=10).
module tb_dff_to_jkff_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic [3:0] q;
    logic [3:0] qb;
    logic       tc;
`ifdef DFF_JK_TRACE_EN
    logic [3:0] j_obs;
    logic [3:0] k_obs;
`endif

    int total = 0;
    int bad   = 0;

    dff_to_jkff_counter #(
        .WIDTH  (4),
        .MODULUS(10)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .load (load),
        .din  (din),
        .q    (q),
        .qb   (qb),
        .tc   (tc)
`ifdef DFF_JK_TRACE_EN
        ,
        .j_obs(j_obs),
        .k_obs(k_obs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst  = 1'b0;
        en   = 1'b0;
        up   = 1'b1;
        load = 1'b0;
        din  = 4'h0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        total++;
        if (q !== 4'h0) begin
            bad++;
            $display("FAIL reset_q got=%h want=0", q);
        end
        total++;
        if (qb !== 4'hF) begin
            bad++;
            $display("FAIL reset_qb got=%h want=f", qb);
        end
        total++;
        if (tc !== 1'b0) begin
            bad++;
            $display("FAIL reset_tc got=%b want=0", tc);
        end
    endtask

    task automatic test_count_up();
        logic [3:0] exp;
        idle();
        en = 1'b1;
        up = 1'b1;
        #1;
        total++;
        if (tc !== 1'b0) begin
            bad++;
            $display("FAIL up_tc0 got=%b want=0", tc);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            exp = 4'((i + 1) % 10);
            total++;
            if (q !== exp || qb !== ~exp) begin
                bad++;
                $display("FAIL up_q step=%0d got=%h/%h want=%h", i, q, qb, exp);
            end
            total++;
            if (tc !== (exp == 4'd9)) begin
                bad++;
                $display("FAIL up_tc step=%0d got=%b want=%b", i, tc, exp == 4'd9);
            end
        end
    endtask

    task automatic test_count_down();
        logic [3:0] seq [3];
        seq[0] = 4'd9;
        seq[1] = 4'd8;
        seq[2] = 4'd7;
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        en  = 1'b1;
        up  = 1'b0;
        #1;
        total++;
        if (tc !== 1'b1) begin
            bad++;
            $display("FAIL dn_tc_zero got=%b want=1", tc);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (q !== seq[i] || tc !== 1'b0) begin
                bad++;
                $display("FAIL dn_q step=%0d got=%h tc=%b want=%h tc=0",
                         i, q, tc, seq[i]);
            end
        end
    endtask

    task automatic test_load_recovery();
        idle();
        load = 1'b1;
        din  = 4'hC;
        step();
        total++;
        if (q !== 4'hC) begin
            bad++;
            $display("FAIL load_c got=%h want=c", q);
        end
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        #1;
        total++;
        if (tc !== 1'b1) begin
            bad++;
            $display("FAIL illegal_tc got=%b want=1", tc);
        end
        step();
        total++;
        if (q !== 4'h0) begin
            bad++;
            $display("FAIL recover got=%h want=0", q);
        end
        load = 1'b1;
        din  = 4'd12;
        up   = 1'b0;
        step();
        total++;
        if (q !== 4'd12) begin
            bad++;
            $display("FAIL load_wins got=%h want=c", q);
        end
        load = 1'b0;
        step();
        total++;
        if (q !== 4'd11) begin
            bad++;
            $display("FAIL illegal_dn got=%h want=b", q);
        end
    endtask

    task automatic test_rst_load();
        idle();
        rst  = 1'b1;
        load = 1'b1;
        en   = 1'b1;
        din  = 4'd5;
        step();
        total++;
        if (q !== 4'h0) begin
            bad++;
            $display("FAIL rst_over_load got=%h want=0", q);
        end
        rst = 1'b0;
        en  = 1'b0;
        step();
        total++;
        if (q !== 4'd5) begin
            bad++;
            $display("FAIL load_after got=%h want=5", q);
        end
    endtask

    task automatic test_hold();
        idle();
        repeat (3) step();
        total++;
        if (q !== 4'd5 || tc !== 1'b0) begin
            bad++;
            $display("FAIL hold got=%h tc=%b want=5 tc=0", q, tc);
        end
    endtask

    task automatic test_direction_change();
        idle();
        en = 1'b1;
        up = 1'b1;
        step();
        total++;
        if (q !== 4'd6) begin
            bad++;
            $display("FAIL dir_up got=%h want=6", q);
        end
        up = 1'b0;
        step();
        total++;
        if (q !== 4'd5) begin
            bad++;
            $display("FAIL dir_dn got=%h want=5", q);
        end
    endtask

    task automatic test_mid_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        en  = 1'b1;
        up  = 1'b1;
        repeat (6) step();
        total++;
        if (q !== 4'd6) begin
            bad++;
            $display("FAIL mid_pre got=%h want=6", q);
        end
        rst = 1'b1;
        step();
        total++;
        if (q !== 4'h0 || qb !== 4'hF) begin
            bad++;
            $display("FAIL mid_rst got=%h/%h want=0/f", q, qb);
        end
        rst = 1'b0;
        step();
        total++;
        if (q !== 4'd1) begin
            bad++;
            $display("FAIL mid_resume got=%h want=1", q);
        end
    endtask

`ifdef DFF_JK_TRACE_EN
    task automatic test_trace();
        idle();
        rst = 1'b1;
        en  = 1'b1;
        #1;
        total++;
        if (j_obs !== 4'h0 || k_obs !== 4'h0) begin
            bad++;
            $display("FAIL trace_rst got=%h/%h want=0/0", j_obs, k_obs);
        end
        step();
        rst  = 1'b0;
        en   = 1'b0;
        load = 1'b1;
        din  = 4'd7;
        step();
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        #1;
        total++;
        if (j_obs !== 4'hF || k_obs !== 4'hF) begin
            bad++;
            $display("FAIL trace_7 got=%h/%h want=f/f", j_obs, k_obs);
        end
        step();
        total++;
        if (q !== 4'd8) begin
            bad++;
            $display("FAIL trace_7q got=%h want=8", q);
        end
        step();
        #1;
        total++;
        if (q !== 4'd9 || j_obs !== 4'h0 || k_obs !== 4'h9) begin
            bad++;
            $display("FAIL trace_9 got=%h %h/%h want=9 0/9", q, j_obs, k_obs);
        end
        step();
        total++;
        if (q !== 4'h0) begin
            bad++;
            $display("FAIL trace_9q got=%h want=0", q);
        end
    endtask
`endif

    initial begin
        idle();
        #2;
        test_reset();
        test_count_up();
        test_count_down();
        test_load_recovery();
        test_rst_load();
        test_hold();
        test_direction_change();
        test_mid_reset();
`ifdef DFF_JK_TRACE_EN
        test_trace();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
